// File: rtl/qvalue_argmax_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | qvalue_argmax_pkg: shared fp16 ordering helpers (Rev 1.0)            |
// +----------------------------------------------------------------------+
package qvalue_argmax_pkg;

    localparam int          FP16_W        = 16;
    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [15:0] FP16_NEG_ZERO = 16'h8000;

    // -0 and +0 must compare equal, so -0 is folded onto +0 first.
    function automatic logic [15:0] fp16_norm(input logic [15:0] x);
        return (x == FP16_NEG_ZERO) ? FP16_POS_ZERO : x;
    endfunction

    // Monotonic key: unsigned order of keys equals numeric order of values.
    function automatic logic [15:0] fp16_key(input logic [15:0] x);
        logic [15:0] n;
        n = fp16_norm(x);
        return n[15] ? ~n : (n ^ 16'h8000);
    endfunction

endpackage : qvalue_argmax_pkg
`default_nettype wire

// File: rtl/qvalue_argmax_gt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp16_gt: combinational strict greater-than on fp16 values (Rev 1.0)  |
// +----------------------------------------------------------------------+
module fp16_gt
    import qvalue_argmax_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        a_gt_b
);

    logic [15:0] w_key_a;
    logic [15:0] w_key_b;

    assign w_key_a = fp16_key(a);
    assign w_key_b = fp16_key(b);
    assign a_gt_b  = (w_key_a > w_key_b);

endmodule : fp16_gt
`default_nettype wire

// File: rtl/qvalue_argmax.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | qvalue_argmax: streaming fp16 argmax over N Q-values per frame      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module qvalue_argmax
    import qvalue_argmax_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int IDXW  = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gvalid,
    input  logic             ivalid,
    input  logic [WIDTH-1:0] in,
    output logic             ovalid,
    output logic [IDXW-1:0]  oidx,
    output logic [WIDTH-1:0] omax,
    output logic             busy,
    output logic             err
);

    localparam logic [IDXW-1:0] C_LAST = IDXW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [IDXW-1:0]   r_count;
    logic [IDXW-1:0]   r_bidx;
    logic [WIDTH-1:0]  r_best;
    logic [WIDTH-1:0]  w_in_norm;
    logic              w_in_gt;

    // Stored values are normalised so a winning -0 is reported as +0.
    assign w_in_norm = fp16_norm(in);

    fp16_gt u_gt (
        .a      (in),
        .b      (r_best),
        .a_gt_b (w_in_gt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_bidx  <= '0;
            r_best  <= '0;
            ovalid  <= 1'b0;
            oidx    <= '0;
            omax    <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            ovalid <= 1'b0;
            if (!gvalid) begin
                r_state <= IDLE;
                r_count <= '0;
                busy    <= 1'b0;
                err     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (ivalid) begin
                            r_best  <= w_in_norm;
                            r_bidx  <= '0;
                            r_count <= IDXW'(1);
                            r_state <= SCAN;
                            busy    <= 1'b1;
                        end
                    end
                    SCAN: begin
                        if (ivalid) begin
                            if (w_in_gt) begin
                                r_best <= w_in_norm;
                                r_bidx <= r_count;
                            end
                            // The Nth sample takes part in the final compare.
                            if (r_count == C_LAST) begin
                                r_state <= DONE;
                                busy    <= 1'b0;
                                ovalid  <= 1'b1;
                                oidx    <= w_in_gt ? r_count : r_bidx;
                                omax    <= w_in_gt ? w_in_norm : r_best;
                            end else begin
                                r_count <= r_count + IDXW'(1);
                            end
                        end
                    end
                    DONE: begin
                        if (ivalid) begin
                            err <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_count <= '0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : qvalue_argmax
`default_nettype wire

// File: tb/tb_qvalue_argmax.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_qvalue_argmax: scoreboard bench for qvalue_argmax (Rev 1.0)       |
// +----------------------------------------------------------------------+
module tb_qvalue_argmax;

    localparam int N     = 4;
    localparam int WIDTH = 16;
    localparam int IDXW  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             gvalid;
    logic             ivalid;
    logic [WIDTH-1:0] in;
    logic             ovalid;
    logic [IDXW-1:0]  oidx;
    logic [WIDTH-1:0] omax;
    logic             busy;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;

    logic [17:0] exp_q[$];

    qvalue_argmax #(.N(N), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .gvalid (gvalid),
        .ivalid (ivalid),
        .in     (in),
        .ovalid (ovalid),
        .oidx   (oidx),
        .omax   (omax),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference ordering via sign/magnitude, independent of the key trick.
    function automatic logic [15:0] ref_norm(input logic [15:0] x);
        return (x == 16'h8000) ? 16'h0000 : x;
    endfunction

    function automatic bit ref_gt(input logic [15:0] a_in, input logic [15:0] b_in);
        logic [15:0] a, b;
        a = ref_norm(a_in);
        b = ref_norm(b_in);
        if (a[15] != b[15]) return b[15];
        if (!a[15]) return a[14:0] > b[14:0];
        return a[14:0] < b[14:0];
    endfunction

    always @(negedge clk) begin
        if (ovalid) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_ovalid", 32'd1, 32'd0);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check_val("sb_oidx", 32'(oidx), 32'(e[17:16]));
                check_val("sb_omax", 32'(omax), 32'(e[15:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_frame();
        gvalid = 1'b0;
        tick();
        gvalid = 1'b1;
    endtask

    // v[0] is the first sample in arrival order; gap[i] idle cycles precede sample i.
    task automatic send_frame(input logic [3:0][15:0] v, input logic [3:0][1:0] gap);
        logic [1:0]  bi;
        logic [15:0] bv;
        bi = 2'd0;
        bv = ref_norm(v[0]);
        for (int i = 1; i < N; i++) begin
            if (ref_gt(v[i], bv)) begin
                bi = 2'(i);
                bv = ref_norm(v[i]);
            end
        end
        for (int i = 0; i < N; i++) begin
            repeat (gap[i]) tick();
            if (i == N - 1) exp_q.push_back({bi, bv});
            in     = v[i];
            ivalid = 1'b1;
            tick();
            ivalid = 1'b0;
            check_val("busy", 32'(busy), (i < N - 1) ? 32'd1 : 32'd0);
            check_val("ovalid_latency", 32'(ovalid), (i == N - 1) ? 32'd1 : 32'd0);
        end
        tick();
        check_val("ovalid_pulse", 32'(ovalid), 32'd0);
    endtask

    task automatic send_one(input logic [15:0] v);
        in     = v;
        ivalid = 1'b1;
        tick();
        ivalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][15:0] rv;
        logic [3:0][1:0]  rg;
        rst    = 1'b1;
        gvalid = 1'b0;
        ivalid = 1'b0;
        in     = '0;
        repeat (3) tick();
        check_val("rst_ovalid", 32'(ovalid), 32'd0);
        check_val("rst_oidx",   32'(oidx),   32'd0);
        check_val("rst_omax",   32'(omax),   32'd0);
        check_val("rst_busy",   32'(busy),   32'd0);
        check_val("rst_err",    32'(err),    32'd0);
        rst    = 1'b0;
        gvalid = 1'b1;

        // Packed literals list samples last-first: {s3, s2, s1, s0}.
        send_frame({16'h3E00, 16'h3C00, 16'h4000, 16'h3800}, '0);
        new_frame();
        check_val("hold_oidx", 32'(oidx), 32'd1);
        check_val("hold_omax", 32'(omax), 32'h4000);
        send_frame({16'hC000, 16'h0000, 16'h8000, 16'hBC00}, '0);
        new_frame();
        send_frame({16'h3C00, 16'h3C00, 16'h0000, 16'h0000}, '0);
        new_frame();
        send_frame({16'h4400, 16'h0000, 16'h0000, 16'h0000}, {2'd3, 2'd2, 2'd1, 2'd0});
        new_frame();

        send_frame({16'h3E00, 16'h3C00, 16'h4000, 16'h3800}, '0);
        check_val("err_before_overrun", 32'(err), 32'd0);
        send_one(16'h7C00);
        check_val("err_overrun", 32'(err), 32'd1);
        check_val("overrun_ovalid", 32'(ovalid), 32'd0);
        check_val("overrun_oidx", 32'(oidx), 32'd1);
        check_val("overrun_omax", 32'(omax), 32'h4000);
        gvalid = 1'b0;
        tick();
        check_val("err_cleared", 32'(err), 32'd0);
        gvalid = 1'b1;
        send_frame({16'h3C00, 16'h3C00, 16'h3C00, 16'h4000}, '0);
        new_frame();

        send_one(16'h4400);
        send_one(16'h4800);
        check_val("abort_busy_on", 32'(busy), 32'd1);
        gvalid = 1'b0;
        tick();
        check_val("abort_busy_off", 32'(busy), 32'd0);
        check_val("abort_ovalid", 32'(ovalid), 32'd0);
        check_val("abort_oidx", 32'(oidx), 32'd0);
        check_val("abort_omax", 32'(omax), 32'h4000);
        tick();
        gvalid = 1'b1;

        send_one(16'h4400);
        send_one(16'h4800);
        rst = 1'b1;
        tick();
        check_val("midrst_ovalid", 32'(ovalid), 32'd0);
        check_val("midrst_oidx", 32'(oidx), 32'd0);
        check_val("midrst_omax", 32'(omax), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        send_frame({16'h4100, 16'h4500, 16'h4200, 16'h3C00}, '0);
        new_frame();

        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < N; i++) begin
                rv[i] = 16'($urandom);
                if (rv[i][14:10] == 5'h1F) rv[i][14:10] = 5'h1E;
                rg[i] = 2'($urandom_range(0, 2));
            end
            send_frame(rv, rg);
            new_frame();
        end

        repeat (2) tick();
        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_qvalue_argmax
`default_nettype wire
